// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port arbiter: lane identifiers, read tags
// and the arbiter FSM encoding.
package dmem_pkg;

    localparam int STRB_W = 4;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_e;

    typedef struct packed {
        lane_e lane;
        logic  killed;
    } rd_tag_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // An all-zero strobe vector marks a load.
    function automatic logic is_read(input logic [STRB_W-1:0] we);
        return (we == {STRB_W{1'b0}});
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two lane request/response ports and the shared memory port.
// The slave modport is the arbiter's view; master is the core/memory side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import dmem_pkg::*;

    logic              a_req;
    logic [STRB_W-1:0] a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic [STRB_W-1:0] b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_we;
    logic              mem_re;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_req, mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_req, mem_addr, mem_wdata, mem_we, mem_re,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/dmem_tag_fifo.sv
// In-order FIFO of read tags (issuing lane + killed flag) for reads that were
// captured toward memory but not yet answered.
module dmem_tag_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  rd_tag_t          push_tag,
    input  logic             pop,
    input  logic             kill_all,
    output rd_tag_t          head_tag,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    rd_tag_t          tags_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    rd_tag_t          wr_tag_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // A tag written in the same cycle as a flush must already be killed.
    always_comb begin
        wr_tag_s        = push_tag;
        wr_tag_s.killed = push_tag.killed | kill_all;
    end

    // Tag storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_r[i] <= '{lane: LANE_A, killed: 1'b0};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (kill_all) begin
                for (int i = 0; i < DEPTH; i++) begin
                    tags_r[i].killed <= 1'b1;
                end
            end
            if (push) begin
                tags_r[wr_ptr_r] <= wr_tag_s;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_tag = tags_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the two issue lanes. Lane A (older) wins
// conflicts; the captured request is held on mem_* until the memory accepts it.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 2,
    parameter int ADDR_W             = 32,
    parameter int DATA_W             = 32
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    dmem_port_arbiter_if.slave bus,
    output logic               busy,
    output logic               proto_err
);

    localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [STRB_W-1:0] mem_we_r;
    logic              proto_err_r;

    logic              a_elig_s;
    logic              b_elig_s;
    logic              win_a_s;
    logic              win_b_s;
    logic              any_win_s;
    logic              capture_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [STRB_W-1:0] sel_we_s;
    logic              push_s;
    logic              pop_s;
    logic              deliver_s;
    rd_tag_t           push_tag_s;
    rd_tag_t           head_tag_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    dmem_tag_fifo #(
        .DEPTH (MAX_RD_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_s),
        .push_tag (push_tag_s),
        .pop      (pop_s),
        .kill_all (flush),
        .head_tag (head_tag_s),
        .count    (fifo_count_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // Eligibility and fixed-priority winner; a pop in this cycle does not free a slot.
    always_comb begin
        a_elig_s  = bus.a_req & (~is_read(bus.a_we) | ~fifo_full_s);
        b_elig_s  = bus.b_req & (~is_read(bus.b_we) | ~fifo_full_s);
        win_a_s   = a_elig_s;
        win_b_s   = ~a_elig_s & b_elig_s;
        any_win_s = win_a_s | win_b_s;
        push_tag_s = '{lane: LANE_A, killed: 1'b0};
        if (win_a_s) begin
            sel_addr_s  = bus.a_addr;
            sel_wdata_s = bus.a_wdata;
            sel_we_s    = bus.a_we;
        end else begin
            sel_addr_s      = bus.b_addr;
            sel_wdata_s     = bus.b_wdata;
            sel_we_s        = bus.b_we;
            push_tag_s.lane = LANE_B;
        end
    end

    // FSM next state: capture in IDLE, or back-to-back in HOLD once the held request is taken.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_win_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (bus.mem_ready) begin
                    if (any_win_s) begin
                        capture_s   = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign push_s    = capture_s & is_read(sel_we_s);
    assign pop_s     = bus.mem_rvalid & ~fifo_empty_s;
    assign deliver_s = pop_s & ~head_tag_s.killed & ~flush;

    // State, held memory request and the sticky protocol error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= {STRB_W{1'b0}};
            proto_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
                mem_we_r    <= sel_we_s;
            end
            if (bus.mem_rvalid & fifo_empty_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign bus.a_gnt     = capture_s & win_a_s;
    assign bus.b_gnt     = capture_s & win_b_s;
    assign bus.a_rvalid  = deliver_s & (head_tag_s.lane == LANE_A);
    assign bus.b_rvalid  = deliver_s & (head_tag_s.lane == LANE_B);
    assign bus.a_rdata   = bus.a_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.b_rdata   = bus.b_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.mem_req   = (state_r == HOLD);
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = (state_r == HOLD) & is_read(mem_we_r);
    assign busy          = (state_r == HOLD) | (fifo_count_s != {CNT_W{1'b0}});
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: read responses are checked against a
// scoreboard filled when the lane request is driven.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    typedef struct {
        lane_e       lane;
        logic [31:0] data;
    } resp_t;

    logic  clk;
    logic  reset_n;
    logic  flush;
    logic  busy;
    logic  proto_err;
    int    n_tests = 0;
    int    n_fail  = 0;
    resp_t exp_q [$];

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_port_arbiter #(
        .MAX_RD_OUTSTANDING (2),
        .ADDR_W             (32),
        .DATA_W             (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (tests=%0d)", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_resp(input lane_e lane, input logic [31:0] data);
        resp_t r;
        r.lane = lane;
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Sample away from the active edge and retire any delivered response.
    task automatic settle();
        resp_t       e;
        logic [33:0] obs;
        @(negedge clk);
        if (bus.a_rvalid || bus.b_rvalid) begin
            obs = {bus.a_rvalid, bus.b_rvalid, (bus.a_rvalid ? bus.a_rdata : bus.b_rdata)};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp", 64'(obs), 64'({(e.lane == LANE_A), (e.lane == LANE_B), e.data}));
            end else begin
                chk("unexpected_resp", 64'(obs), 64'h0);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        flush          = 1'b0;
        bus.a_req      = 1'b0;
        bus.a_we       = 4'h0;
        bus.a_addr     = 32'h0;
        bus.a_wdata    = 32'h0;
        bus.b_req      = 1'b0;
        bus.b_we       = 4'h0;
        bus.b_addr     = 32'h0;
        bus.b_wdata    = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        adv();
        adv();
        settle();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_re", bus.mem_re, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_we", bus.mem_we, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        adv();
        reset_n = 1'b1;

        // 1: single lane A read
        bus.a_req = 1'b1; bus.a_we = 4'h0; bus.a_addr = 32'h100; bus.mem_ready = 1'b1;
        settle();
        chk("t1_a_gnt", bus.a_gnt, 1'b1);
        chk("t1_b_gnt", bus.b_gnt, 1'b0);
        chk("t1_mem_req_lat", bus.mem_req, 1'b0);
        expect_resp(LANE_A, 32'hDEADBEEF);
        adv();
        bus.a_req = 1'b0;
        settle();
        chk("t1_mem_req", bus.mem_req, 1'b1);
        chk("t1_mem_re", bus.mem_re, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        adv();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        settle();
        chk("t1_a_rvalid", bus.a_rvalid, 1'b1);
        chk("t1_a_rdata", bus.a_rdata, 32'hDEADBEEF);
        chk("t1_b_rvalid", bus.b_rvalid, 1'b0);
        chk("t1_b_rdata", bus.b_rdata, 32'h0);
        adv();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t1_busy_end", busy, 1'b0);
        adv();

        // 2: A write and B read in the same cycle
        bus.a_req = 1'b1; bus.a_we = 4'hF; bus.a_addr = 32'h200; bus.a_wdata = 32'h11112222;
        bus.b_req = 1'b1; bus.b_we = 4'h0; bus.b_addr = 32'h300;
        settle();
        chk("t2_a_gnt", bus.a_gnt, 1'b1);
        chk("t2_b_gnt_blocked", bus.b_gnt, 1'b0);
        adv();
        bus.a_req = 1'b0;
        settle();
        chk("t2_b_gnt", bus.b_gnt, 1'b1);
        chk("t2_mem_addr_a", bus.mem_addr, 32'h200);
        chk("t2_mem_wdata_a", bus.mem_wdata, 32'h11112222);
        chk("t2_mem_we_a", bus.mem_we, 4'hF);
        chk("t2_mem_re_a", bus.mem_re, 1'b0);
        expect_resp(LANE_B, 32'hCAFEF00D);
        adv();
        bus.b_req = 1'b0;
        settle();
        chk("t2_mem_addr_b", bus.mem_addr, 32'h300);
        chk("t2_mem_re_b", bus.mem_re, 1'b1);
        adv();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        settle();
        chk("t2_b_rvalid", bus.b_rvalid, 1'b1);
        chk("t2_a_rvalid", bus.a_rvalid, 1'b0);
        adv();
        bus.mem_rvalid = 1'b0;

        // 3: memory stalls while B waits
        bus.mem_ready = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 4'hF; bus.a_addr = 32'h400; bus.a_wdata = 32'hA5A5A5A5;
        settle();
        chk("t3_a_gnt", bus.a_gnt, 1'b1);
        adv();
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 4'h3; bus.b_addr = 32'h500; bus.b_wdata = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_stall_mem_req", bus.mem_req, 1'b1);
            chk("t3_stall_mem_addr", bus.mem_addr, 32'h400);
            chk("t3_stall_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
            chk("t3_stall_b_gnt", bus.b_gnt, 1'b0);
            adv();
        end
        bus.mem_ready = 1'b1;
        settle();
        chk("t3_b_gnt", bus.b_gnt, 1'b1);
        chk("t3_mem_addr_held", bus.mem_addr, 32'h400);
        adv();
        bus.b_req = 1'b0;
        settle();
        chk("t3_mem_addr_b", bus.mem_addr, 32'h500);
        chk("t3_mem_we_b", bus.mem_we, 4'h3);
        adv();
        settle();
        chk("t3_idle_mem_req", bus.mem_req, 1'b0);
        chk("t3_idle_busy", busy, 1'b0);
        adv();

        // 4: read slots exhausted; a pop frees a slot only from the next cycle
        bus.a_req = 1'b1; bus.a_we = 4'h0; bus.a_addr = 32'h600;
        settle();
        chk("t4_gnt1", bus.a_gnt, 1'b1);
        expect_resp(LANE_A, 32'h60000001);
        adv();
        bus.a_addr = 32'h604;
        settle();
        chk("t4_gnt2", bus.a_gnt, 1'b1);
        expect_resp(LANE_A, 32'h60000002);
        adv();
        bus.a_addr = 32'h608;
        settle();
        chk("t4_full_no_gnt", bus.a_gnt, 1'b0);
        chk("t4_busy", busy, 1'b1);
        adv();
        bus.b_req = 1'b1; bus.b_we = 4'hF; bus.b_addr = 32'h6F0;
        settle();
        chk("t4_a_blocked", bus.a_gnt, 1'b0);
        chk("t4_b_write_passes", bus.b_gnt, 1'b1);
        adv();
        bus.b_req = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h60000001;
        settle();
        chk("t4_pop_no_gnt", bus.a_gnt, 1'b0);
        chk("t4_rvalid1", bus.a_rvalid, 1'b1);
        adv();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t4_gnt3", bus.a_gnt, 1'b1);
        expect_resp(LANE_A, 32'h60000003);
        adv();
        bus.a_req = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h60000002;
        settle();
        chk("t4_mem_addr3", bus.mem_addr, 32'h608);
        chk("t4_rvalid2", bus.a_rvalid, 1'b1);
        adv();
        bus.mem_rdata = 32'h60000003;
        settle();
        chk("t4_rdata3", bus.a_rdata, 32'h60000003);
        adv();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t4_busy_end", busy, 1'b0);
        adv();

        // 5: flush kills two outstanding reads
        bus.a_req = 1'b1; bus.a_we = 4'h0; bus.a_addr = 32'h700;
        bus.b_req = 1'b1; bus.b_we = 4'h0; bus.b_addr = 32'h704;
        settle();
        adv();
        bus.a_req = 1'b0;
        settle();
        chk("t5_b_gnt", bus.b_gnt, 1'b1);
        adv();
        bus.b_req = 1'b0;
        flush = 1'b1;
        settle();
        adv();
        flush = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77770000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t5_busy_during", busy, 1'b1);
            chk("t5_a_rvalid_killed", bus.a_rvalid, 1'b0);
            chk("t5_b_rvalid_killed", bus.b_rvalid, 1'b0);
            adv();
        end
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t5_busy_end", busy, 1'b0);
        adv();

        // 5b: flush on the push cycle, push+pop, and flush with a same-cycle response
        bus.a_req = 1'b1; bus.a_we = 4'h0; bus.a_addr = 32'h800;
        flush = 1'b1;
        settle();
        chk("t5b_gnt_with_flush", bus.a_gnt, 1'b1);
        adv();
        bus.a_req = 1'b0;
        flush = 1'b0;
        settle();
        adv();
        bus.a_req = 1'b1; bus.a_addr = 32'h804;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55555555;
        settle();
        chk("t5b_push_pop_gnt", bus.a_gnt, 1'b1);
        chk("t5b_killed_same_push", bus.a_rvalid, 1'b0);
        adv();
        bus.a_req = 1'b0;
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t5b_busy_one_left", busy, 1'b1);
        adv();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h66666666;
        flush = 1'b1;
        settle();
        chk("t5b_flush_with_rvalid", bus.a_rvalid, 1'b0);
        adv();
        bus.mem_rvalid = 1'b0;
        flush = 1'b0;
        settle();
        chk("t5b_busy_end", busy, 1'b0);
        chk("t5b_no_proto_err", proto_err, 1'b0);
        adv();

        // 6: response with nothing outstanding, then reset in the middle of a held request
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        settle();
        chk("t6_stray_no_rvalid", bus.a_rvalid | bus.b_rvalid, 1'b0);
        adv();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("t6_proto_err_set", proto_err, 1'b1);
        adv();
        bus.mem_ready = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 4'hF; bus.a_addr = 32'h900;
        settle();
        chk("t6_proto_err_sticky", proto_err, 1'b1);
        chk("t6_a_gnt", bus.a_gnt, 1'b1);
        adv();
        bus.a_req = 1'b0;
        settle();
        chk("t6_hold_mem_req", bus.mem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_mem_req", bus.mem_req, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_proto_err", proto_err, 1'b0);
        chk("t6_async_mem_addr", bus.mem_addr, 32'h0);
        adv();
        reset_n = 1'b1;
        settle();
        chk("t6_after_reset_mem_req", bus.mem_req, 1'b0);
        adv();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
